// File: rtl/tick_stopwatch_if.sv
//------------------------------------------------------------------------------
// Module   : tick_stopwatch_if
// Purpose  : Control/status bundle for tick_stopwatch (lap signals when STOPWATCH_LAP_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tick_stopwatch_if;
  logic       tick_i;
  logic       start_stop_i;
  logic       clear_i;
  logic [7:0] count_bcd_o;
  logic       running_o;
  logic       tc_o;
`ifdef STOPWATCH_LAP_EN
  logic       lap_i;
  logic [7:0] lap_bcd_o;

  modport slave (
    input  tick_i, start_stop_i, clear_i, lap_i,
    output count_bcd_o, running_o, tc_o, lap_bcd_o
  );
  modport master (
    output tick_i, start_stop_i, clear_i, lap_i,
    input  count_bcd_o, running_o, tc_o, lap_bcd_o
  );
`else
  modport slave (
    input  tick_i, start_stop_i, clear_i,
    output count_bcd_o, running_o, tc_o
  );
  modport master (
    output tick_i, start_stop_i, clear_i,
    input  count_bcd_o, running_o, tc_o
  );
`endif
endinterface

`default_nettype wire

// File: rtl/tick_stopwatch.sv
//------------------------------------------------------------------------------
// Module   : tick_stopwatch
// Purpose  : 2-digit BCD stopwatch counting rising edges of a divided tick;
//            optional lap capture enabled by macro STOPWATCH_LAP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_stopwatch #(
  parameter logic [7:0] WRAP_BCD = 8'h99
) (
  input  wire               clk,
  input  wire               nrst,
  tick_stopwatch_if.slave   bus
);

  localparam logic [3:0] c_wrap_tens = WRAP_BCD[7:4];
  localparam logic [3:0] c_wrap_ones = WRAP_BCD[3:0];

  if ((c_wrap_tens > 4'd9) || (c_wrap_ones > 4'd9)) begin : g_bad_wrap
    $error("tick_stopwatch: WRAP_BCD has a non-BCD digit");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       tc_q, tc_d;
  logic       running_q, running_d;
  logic       tick_q;
  logic       w_tick_rise;

  assign w_tick_rise = bus.tick_i & ~tick_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      count_q   <= 8'h00;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      running_q <= running_d;
      tick_q    <= bus.tick_i;
    end
  end

  // A tick in RUN is counted even when start_stop pauses in the same cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.clear_i) begin
      state_d = IDLE;
      count_d = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = 8'h00;
          if (bus.start_stop_i) state_d = RUN;
        end
        RUN: begin
          if (w_tick_rise) begin
            if (count_q == WRAP_BCD) begin
              count_d = 8'h00;
              tc_d    = 1'b1;
            end else if (count_q[3:0] == 4'd9) begin
              count_d = {count_q[7:4] + 4'd1, 4'd0};
            end else begin
              count_d = {count_q[7:4], count_q[3:0] + 4'd1};
            end
          end
          if (bus.start_stop_i) state_d = PAUSE;
        end
        PAUSE: begin
          if (bus.start_stop_i) state_d = RUN;
        end
        default: begin
          state_d = IDLE;
          count_d = 8'h00;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  assign bus.count_bcd_o = count_q;
  assign bus.running_o   = running_q;
  assign bus.tc_o        = tc_q;

`ifdef STOPWATCH_LAP_EN
  logic [7:0] lap_q, lap_d;

  // Snapshot is the pre-increment count; clear wins over lap.
  always_comb begin
    lap_d = lap_q;
    if (bus.clear_i)    lap_d = 8'h00;
    else if (bus.lap_i) lap_d = count_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) lap_q <= 8'h00;
    else       lap_q <= lap_d;
  end

  assign bus.lap_bcd_o = lap_q;
`endif

endmodule

`default_nettype wire
